cfg_mem_arbiter: RTL and testbench

CFG_MEM_ARBITER -- requirements
Module: cfg_mem_arbiter

---
 rtl/cfg_arb_pkg.sv | 19 +
 rtl/cfg_arb_rr2.sv | 37 +++
 rtl/cfg_mem_arbiter.sv | 214 +++++++++++++++++++++
 tb/tb_cfg_mem_arbiter.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cfg_arb_pkg.sv
// Shared types and constants for the configuration-memory arbiter.
package cfg_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_RDWAIT = 2'd2,
        ST_RESP   = 2'd3
    } arb_state_t;

    typedef enum logic {
        REQ_WB = 1'b0,
        REQ_LA = 1'b1
    } req_id_t;

    // Read data returned when a request is abandoned for lack of grant.
    localparam logic [31:0] POISON = 32'hDEAD_BEEF;

endpackage

// File: rtl/cfg_arb_rr2.sv
// Two-way round-robin picker between the Wishbone and LA requesters.
// The tie-break pointer only moves when both requesters compete, so the
// first tie after reset always goes to Wishbone.
module cfg_arb_rr2
    import cfg_arb_pkg::*;
(
    input  logic    clk,
    input  logic    rst_n,
    input  logic    i_req_wb,
    input  logic    i_req_la,
    input  logic    i_take,
    output req_id_t o_winner
);

    req_id_t r_last;
    logic    w_tie;

    assign w_tie = i_req_wb & i_req_la;

    // Pick the winner: a lone requester wins, a tie goes to whoever lost last time.
    always_comb begin
        o_winner = REQ_WB;
        if (w_tie)
            o_winner = (r_last == REQ_WB) ? REQ_LA : REQ_WB;
        else if (i_req_la)
            o_winner = REQ_LA;
    end

    // Remember the winner of the most recent tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_last <= REQ_LA;
        else if (i_take && w_tie)
            r_last <= o_winner;
    end

endmodule

// File: rtl/cfg_mem_arbiter.sv
// Arbiter sharing one configuration memory between a Wishbone slave port
// and a logic-analyzer debug port.
// Optional feature: define CFG_ARB_TIMEOUT_EN to abort a request that never
// receives mem_gnt_i after TIMEOUT cycles (returns POISON, sets err_o).
//
// state     | meaning
// ----------+--------------------------------------------------------
// ST_IDLE   | waiting for a request; latches the winner's fields
// ST_ISSUE  | mem_req_o high, latched fields stable, waiting for grant
// ST_RDWAIT | read granted; capture mem_dat_i this cycle
// ST_RESP   | one-cycle ack to the winner with captured data
module cfg_mem_arbiter
    import cfg_arb_pkg::*;
#(
    parameter int          ADDR_W   = 10,
    parameter logic [31:0] BASE_ADR = 32'h3000_0000,
    parameter int          TIMEOUT  = 64
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_n_i,
    input  logic              wbs_cyc_i,
    input  logic              wbs_stb_i,
    input  logic              wbs_we_i,
    input  logic [31:0]       wbs_adr_i,
    input  logic [31:0]       wbs_dat_i,
    input  logic [3:0]        wbs_sel_i,
    output logic              wbs_ack_o,
    output logic [31:0]       wbs_dat_o,
    input  logic              la_req_i,
    input  logic              la_we_i,
    input  logic [ADDR_W-1:0] la_adr_i,
    input  logic [31:0]       la_dat_i,
    output logic              la_ack_o,
    output logic [31:0]       la_dat_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_adr_o,
    output logic [31:0]       mem_dat_o,
    output logic [3:0]        mem_wmask_o,
    input  logic              mem_gnt_i,
    input  logic [31:0]       mem_dat_i,
    output logic              err_o
);

    logic              r_rst_n_q;
    arb_state_t        r_state;
    arb_state_t        w_state_nxt;
    req_id_t           r_owner;
    req_id_t           w_winner;
    logic              r_we;
    logic [ADDR_W-1:0] r_adr;
    logic [31:0]       r_wdat;
    logic [3:0]        r_mask;
    logic [31:0]       r_wb_dat;
    logic [31:0]       r_la_dat;
    logic              w_wb_req;
    logic              w_take;
    logic              w_enter_resp;
    logic [31:0]       w_resp_data;
    logic              w_unused;
`ifdef CFG_ARB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [CNT_W-1:0]  r_tmo_cnt;
    logic              r_err;
    logic              w_abort;
`endif

    // Byte-lane bits of the Wishbone address are not used for word addressing.
    assign w_unused = &{1'b0, wbs_adr_i[1:0], (TIMEOUT > 0)};

    assign w_wb_req = wbs_cyc_i & wbs_stb_i
                    & (wbs_adr_i[31:ADDR_W+2] == BASE_ADR[31:ADDR_W+2]);

    // Reset asserts asynchronously and releases on the next clock edge.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i)
            r_rst_n_q <= 1'b0;
        else
            r_rst_n_q <= 1'b1;
    end

    cfg_arb_rr2 u_rr2 (
        .clk      (wb_clk_i),
        .rst_n    (r_rst_n_q),
        .i_req_wb (w_wb_req),
        .i_req_la (la_req_i),
        .i_take   (w_take),
        .o_winner (w_winner)
    );

    // State register.
    always_ff @(posedge wb_clk_i or negedge r_rst_n_q) begin
        if (!r_rst_n_q)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Next state, acceptance strobe and the data to return on entering RESP.
    always_comb begin
        w_state_nxt  = r_state;
        w_take       = 1'b0;
        w_enter_resp = 1'b0;
        w_resp_data  = '0;
`ifdef CFG_ARB_TIMEOUT_EN
        w_abort      = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                if (w_wb_req || la_req_i) begin
                    w_take      = 1'b1;
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (mem_gnt_i) begin
                    if (r_we) begin
                        w_state_nxt  = ST_RESP;
                        w_enter_resp = 1'b1;
                    end else begin
                        w_state_nxt  = ST_RDWAIT;
                    end
                end
`ifdef CFG_ARB_TIMEOUT_EN
                else if (r_tmo_cnt == '0) begin
                    w_state_nxt  = ST_RESP;
                    w_enter_resp = 1'b1;
                    w_resp_data  = POISON;
                    w_abort      = 1'b1;
                end
`endif
            end
            ST_RDWAIT: begin
                w_state_nxt  = ST_RESP;
                w_enter_resp = 1'b1;
                w_resp_data  = mem_dat_i;
            end
            ST_RESP:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Latch the winner's request fields; they stay stable through ISSUE.
    always_ff @(posedge wb_clk_i or negedge r_rst_n_q) begin
        if (!r_rst_n_q) begin
            r_owner <= REQ_WB;
            r_we    <= 1'b0;
            r_adr   <= '0;
            r_wdat  <= '0;
            r_mask  <= '0;
        end else if (w_take) begin
            r_owner <= w_winner;
            if (w_winner == REQ_WB) begin
                r_we   <= wbs_we_i;
                r_adr  <= wbs_adr_i[ADDR_W+1:2];
                r_wdat <= wbs_dat_i;
                r_mask <= wbs_sel_i;
            end else begin
                r_we   <= la_we_i;
                r_adr  <= la_adr_i;
                r_wdat <= la_dat_i;
                r_mask <= 4'hF;
            end
        end
    end

    // Per-requester read data, updated only when that requester is answered.
    always_ff @(posedge wb_clk_i or negedge r_rst_n_q) begin
        if (!r_rst_n_q) begin
            r_wb_dat <= '0;
            r_la_dat <= '0;
        end else if (w_enter_resp) begin
            if (r_owner == REQ_WB)
                r_wb_dat <= w_resp_data;
            else
                r_la_dat <= w_resp_data;
        end
    end

`ifdef CFG_ARB_TIMEOUT_EN
    // Grant-wait down-counter, loaded on acceptance, terminal count at zero.
    always_ff @(posedge wb_clk_i or negedge r_rst_n_q) begin
        if (!r_rst_n_q)
            r_tmo_cnt <= '0;
        else if (w_take)
            r_tmo_cnt <= CNT_W'(TIMEOUT - 1);
        else if (r_state == ST_ISSUE && !mem_gnt_i && r_tmo_cnt != '0)
            r_tmo_cnt <= r_tmo_cnt - 1'b1;
    end

    // Sticky abort flag; only reset clears it.
    always_ff @(posedge wb_clk_i or negedge r_rst_n_q) begin
        if (!r_rst_n_q)
            r_err <= 1'b0;
        else if (w_abort)
            r_err <= 1'b1;
    end

    assign err_o = r_err;
`else
    assign err_o = 1'b0;
`endif

    assign mem_req_o   = (r_state == ST_ISSUE);
    assign mem_we_o    = r_we;
    assign mem_adr_o   = r_adr;
    assign mem_dat_o   = r_wdat;
    assign mem_wmask_o = r_mask;
    assign wbs_ack_o   = (r_state == ST_RESP) && (r_owner == REQ_WB);
    assign la_ack_o    = (r_state == ST_RESP) && (r_owner == REQ_LA);
    assign wbs_dat_o   = r_wb_dat;
    assign la_dat_o    = r_la_dat;

endmodule

// File: tb/tb_cfg_mem_arbiter.sv
// Scoreboard bench for cfg_mem_arbiter: stimulus pushes expected memory
// requests and acks; a negedge monitor pops and compares.
module tb_cfg_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wbs_cyc_i, wbs_stb_i, wbs_we_i;
    logic [31:0] wbs_adr_i, wbs_dat_i;
    logic [3:0]  wbs_sel_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic        la_req_i, la_we_i;
    logic [9:0]  la_adr_i;
    logic [31:0] la_dat_i;
    logic        la_ack_o;
    logic [31:0] la_dat_o;
    logic        mem_req_o, mem_we_o;
    logic [9:0]  mem_adr_o;
    logic [31:0] mem_dat_o;
    logic [3:0]  mem_wmask_o;
    logic        mem_gnt_i;
    logic [31:0] mem_dat_i;
    logic        err_o;

    always #5 clk = ~clk;

    cfg_mem_arbiter #(.ADDR_W(10), .BASE_ADR(32'h3000_0000), .TIMEOUT(64)) dut (
        .wb_clk_i(clk), .wb_rst_n_i(rst_n),
        .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
        .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i), .wbs_sel_i(wbs_sel_i),
        .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
        .la_req_i(la_req_i), .la_we_i(la_we_i), .la_adr_i(la_adr_i), .la_dat_i(la_dat_i),
        .la_ack_o(la_ack_o), .la_dat_o(la_dat_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_adr_o(mem_adr_o),
        .mem_dat_o(mem_dat_o), .mem_wmask_o(mem_wmask_o),
        .mem_gnt_i(mem_gnt_i), .mem_dat_i(mem_dat_i), .err_o(err_o)
    );

    typedef struct { bit is_la; logic [31:0] data; int cyc; } rsp_t;
    typedef struct { logic we; logic [9:0] adr; logic [31:0] dat; logic [3:0] mask; } mreq_t;

    rsp_t  rsp_q[$];
    mreq_t mem_q[$];
    int total = 0;
    int bad = 0;
    int cyc = 0;
    int n_ack = 0;
    int n_memreq = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: compare memory grants and acks against the scoreboard queues.
    always @(negedge clk) begin : monitor
        rsp_t  r;
        mreq_t m;
        if (mem_req_o && mem_gnt_i) begin
            n_memreq++;
            if (mem_q.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_mem_req: adr %h seen, none expected", mem_adr_o);
            end else begin
                m = mem_q.pop_front();
                chk("mem_we", mem_we_o, m.we);
                chk("mem_adr", mem_adr_o, m.adr);
                if (m.we) begin
                    chk("mem_dat", mem_dat_o, m.dat);
                    chk("mem_wmask", mem_wmask_o, m.mask);
                end
            end
        end
        if (wbs_ack_o || la_ack_o) begin
            n_ack++;
            if (rsp_q.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_ack: wb=%b la=%b, none expected", wbs_ack_o, la_ack_o);
            end else begin
                r = rsp_q.pop_front();
                chk("ack_src", {wbs_ack_o, la_ack_o}, r.is_la ? 2'b01 : 2'b10);
                chk("ack_data", r.is_la ? la_dat_o : wbs_dat_o, r.data);
                chk("ack_cycle", cyc, r.cyc);
            end
        end
    end

    // One-cycle Wishbone request; expectations pushed when push is set.
    task automatic wb_txn(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel, input logic [9:0] exp_adr,
                          input logic [31:0] exp_rd, input int extra, input bit push);
        mreq_t m;
        rsp_t  r;
        @(posedge clk); #1;
        wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = we;
        wbs_adr_i = adr; wbs_dat_i = dat; wbs_sel_i = sel;
        if (push) begin
            m.we = we; m.adr = exp_adr; m.dat = dat; m.mask = sel;
            mem_q.push_back(m);
            r.is_la = 0; r.data = exp_rd; r.cyc = cyc + (we ? 2 : 3) + extra;
            rsp_q.push_back(r);
        end
        @(posedge clk); #1;
        wbs_cyc_i = 0; wbs_stb_i = 0;
    endtask

    task automatic la_txn(input logic we, input logic [9:0] adr, input logic [31:0] dat,
                          input logic [31:0] exp_rd);
        mreq_t m;
        rsp_t  r;
        @(posedge clk); #1;
        la_req_i = 1; la_we_i = we; la_adr_i = adr; la_dat_i = dat;
        m.we = we; m.adr = adr; m.dat = dat; m.mask = 4'hF;
        mem_q.push_back(m);
        r.is_la = 1; r.data = exp_rd; r.cyc = cyc + (we ? 2 : 3);
        rsp_q.push_back(r);
        @(posedge clk); #1;
        la_req_i = 0;
    endtask

    // Both requesters write on the same cycle; only the expected winner is pushed.
    task automatic tie_txn(input logic [31:0] wadr, input logic [9:0] wexp_adr,
                           input logic [31:0] wdat, input logic [9:0] ladr,
                           input logic [31:0] ldat, input bit exp_la);
        mreq_t m;
        rsp_t  r;
        @(posedge clk); #1;
        wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 1;
        wbs_adr_i = wadr; wbs_dat_i = wdat; wbs_sel_i = 4'hC;
        la_req_i = 1; la_we_i = 1; la_adr_i = ladr; la_dat_i = ldat;
        if (exp_la) begin
            m.we = 1; m.adr = ladr; m.dat = ldat; m.mask = 4'hF;
        end else begin
            m.we = 1; m.adr = wexp_adr; m.dat = wdat; m.mask = 4'hC;
        end
        mem_q.push_back(m);
        r.is_la = exp_la; r.data = 32'h0; r.cyc = cyc + 2;
        rsp_q.push_back(r);
        @(posedge clk); #1;
        wbs_cyc_i = 0; wbs_stb_i = 0; la_req_i = 0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 200; i++) begin
            if (rsp_q.size() == 0 && mem_q.size() == 0) break;
            @(posedge clk);
        end
        chk(name, rsp_q.size() + mem_q.size(), 0);
        @(posedge clk); #1;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int na, nm;
        rsp_t r;
        rst_n = 0;
        wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0;
        wbs_adr_i = '0; wbs_dat_i = '0; wbs_sel_i = '0;
        la_req_i = 0; la_we_i = 0; la_adr_i = '0; la_dat_i = '0;
        mem_gnt_i = 1; mem_dat_i = '0;

        #12;
        chk("rst_wbs_ack", wbs_ack_o, 0);
        chk("rst_la_ack", la_ack_o, 0);
        chk("rst_mem_req", mem_req_o, 0);
        chk("rst_wbs_dat", wbs_dat_o, 0);
        chk("rst_la_dat", la_dat_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_mem_adr", mem_adr_o, 0);
        chk("rst_mem_wmask", mem_wmask_o, 0);
        rst_n = 1;
        repeat (3) @(posedge clk);

        // WB write, immediate grant
        wb_txn(1, 32'h3000_0010, 32'hA5A5_1234, 4'h3, 10'd4, 32'h0, 0, 1);
        drain("drain_wb_write");

        // LA read
        mem_dat_i = 32'h0BAD_F00D;
        la_txn(0, 10'd4, 32'h0, 32'h0BAD_F00D);
        drain("drain_la_read");

        // WB read at top word of the window
        mem_dat_i = 32'h1234_5678;
        wb_txn(0, 32'h3000_0FFC, 32'h0, 4'hF, 10'd1023, 32'h1234_5678, 0, 1);
        drain("drain_wb_read");
        chk("la_dat_hold", la_dat_o, 32'h0BAD_F00D);
        chk("wbs_dat_hold", wbs_dat_o, 32'h1234_5678);

        // Three ties: WB, LA, WB
        tie_txn(32'h3000_0100, 10'd64, 32'h1111_0001, 10'd100, 32'h2222_0001, 0);
        drain("drain_tie1");
        tie_txn(32'h3000_0104, 10'd65, 32'h1111_0002, 10'd101, 32'h2222_0002, 1);
        drain("drain_tie2");
        tie_txn(32'h3000_0108, 10'd66, 32'h1111_0003, 10'd102, 32'h2222_0003, 0);
        drain("drain_tie3");

        // Out-of-window access is ignored
        na = n_ack; nm = n_memreq;
        wb_txn(1, 32'h3001_0000, 32'hFFFF_0000, 4'hF, 10'd0, 32'h0, 0, 0);
        repeat (8) @(posedge clk);
        #1;
        chk("oow_memreq", n_memreq - nm, 0);
        chk("oow_ack", n_ack - na, 0);
        chk("oow_req_now", mem_req_o, 0);

        // Grant stall of 5 cycles: fields held, ack delayed accordingly
        mem_gnt_i = 0;
        wb_txn(1, 32'h3000_0044, 32'h5555_AAAA, 4'h9, 10'd17, 32'h0, 5, 1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("stall_req", mem_req_o, 1);
            chk("stall_adr", mem_adr_o, 10'd17);
        end
        mem_gnt_i = 1;
        drain("drain_stall");

`ifdef CFG_ARB_TIMEOUT_EN
        // No grant: abort with poison after the timeout
        mem_gnt_i = 0;
        @(posedge clk); #1;
        wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 0;
        wbs_adr_i = 32'h3000_0008; wbs_sel_i = 4'hF;
        r.is_la = 0; r.data = 32'hDEAD_BEEF; r.cyc = cyc + 65;
        rsp_q.push_back(r);
        @(posedge clk); #1;
        wbs_cyc_i = 0; wbs_stb_i = 0;
        drain("drain_timeout");
        chk("tmo_err", err_o, 1);
        chk("tmo_data_hold", wbs_dat_o, 32'hDEAD_BEEF);
`endif

        // Reset while in ISSUE
        mem_gnt_i = 0;
        wb_txn(1, 32'h3000_0030, 32'h7777_7777, 4'hF, 10'd12, 32'h0, 0, 0);
        chk("issue_req_before_rst", mem_req_o, 1);
        #2 rst_n = 0;
        #1;
        chk("rst_issue_mem_req", mem_req_o, 0);
        chk("rst_issue_ack", wbs_ack_o, 0);
        chk("rst_issue_err", err_o, 0);
        chk("rst_issue_wbs_dat", wbs_dat_o, 0);
        @(posedge clk); #1;
        rst_n = 1;
        mem_gnt_i = 1;
        repeat (3) @(posedge clk);
        wb_txn(1, 32'h3000_0020, 32'h1111_2222, 4'hF, 10'd8, 32'h0, 0, 1);
        drain("drain_after_rst");
        chk("final_err", err_o, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
